fetch_dispatch_queue: RTL

//  Instruction queue between the fetch/branch stage and dispatch.
//  - Buffers {instr, pc, predicted_outcome} produced by fetch; dispatch pops entries in order.
//  - Decouples fetch (ihit-driven) from dispatch back-pressure.
//  - Fetch uses enq_ready to stall; a branch mispredict flush empties the queue.

---
 rtl/isa_pkg.sv | 21 ++
 rtl/fetch_dispatch_if.sv | 44 ++++
 rtl/fetch_dispatch_queue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// ----------------------------------------------------------------------------
// isa_pkg
//   Shared ISA-level types.
//   - word_t      : 32-bit machine word (instructions, PCs, data)
//   - fdq_entry_t : one fetch/dispatch queue slot {instr, pc, pred}. It lives
//                   here so that dispatch can reuse the same layout.
//   No ports (package). Configuration macro used by importers: FDQ_BYPASS_EN.
// ----------------------------------------------------------------------------
package isa_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  pred;
    } fdq_entry_t;

    localparam int unsigned FDQ_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_dispatch_if.sv
// ----------------------------------------------------------------------------
// fetch_dispatch_if
//   Bundles the fetch -> queue -> dispatch handshake signals.
//   Ports : CLK, nRST (clock and async active-low reset, shared)
//   Signals: flush, enq_valid/enq_ready, instr_in/pc_in/pred_in (fetch side),
//            deq_valid/deq_ready, instr_out/pc_out/pred_out (dispatch side),
//            count (occupancy).
//   Modports: fdq (the queue itself), tb (the driver/observer of the queue).
//   Configuration macro affecting the attached queue: FDQ_BYPASS_EN.
// ----------------------------------------------------------------------------
interface fetch_dispatch_if
    import isa_pkg::*;
#(
    parameter int unsigned DEPTH = FDQ_DEPTH_DEFAULT
) (
    input logic CLK,
    input logic nRST
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             enq_valid;
    word_t            instr_in;
    word_t            pc_in;
    logic             pred_in;
    logic             enq_ready;
    logic             deq_valid;
    logic             deq_ready;
    word_t            instr_out;
    word_t            pc_out;
    logic             pred_out;
    logic [CNT_W-1:0] count;

    modport fdq (
        input  CLK, nRST, flush, enq_valid, instr_in, pc_in, pred_in, deq_ready,
        output enq_ready, deq_valid, instr_out, pc_out, pred_out, count
    );

    modport tb (
        input  CLK, nRST, enq_ready, deq_valid, instr_out, pc_out, pred_out, count,
        output flush, enq_valid, instr_in, pc_in, pred_in, deq_ready
    );

endinterface

// File: rtl/fetch_dispatch_queue.sv
// ----------------------------------------------------------------------------
// fetch_dispatch_queue
//   In-order instruction queue between fetch/branch and dispatch. Buffers
//   {instr, pc, predicted_outcome}; fetch stalls on enq_ready, dispatch pops
//   the head with deq_ready, and flush (mispredict/redirect) empties it.
//
//   Ports:
//     CLK        in   clock, rising edge
//     nRST       in   asynchronous active-low reset
//     flush      in   discard all entries; overrides enqueue and dequeue
//     enq_valid  in   fetch presents an instruction
//     instr_in   in   [31:0] instruction
//     pc_in      in   [31:0] PC of instr_in
//     pred_in    in   predicted outcome of instr_in
//     enq_ready  out  queue not full (independent of deq_ready)
//     deq_valid  out  head entry valid
//     deq_ready  in   dispatch accepts the head this cycle
//     instr_out  out  [31:0] head instruction
//     pc_out     out  [31:0] head PC
//     pred_out   out  head predicted outcome
//     count      out  [CNT_W-1:0] occupancy 0..DEPTH (registered)
//
//   Parameters: DEPTH (power of 2, >= 2); CNT_W derived.
//   Macro FDQ_BYPASS_EN: when defined, an empty queue forwards enq_* straight
//   to deq_* in the same cycle if dispatch is ready (0-cycle latency). When
//   undefined there is no combinational path from enq_* to deq_*.
// ----------------------------------------------------------------------------
module fetch_dispatch_queue
    import isa_pkg::*;
#(
    parameter  int unsigned DEPTH = FDQ_DEPTH_DEFAULT,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             enq_valid,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      pc_in,
    input  logic             pred_in,
    output logic             enq_ready,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc_out,
    output logic             pred_out,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    fdq_entry_t       mem [DEPTH];
    fdq_entry_t       head;
    fdq_entry_t       wr_entry;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             enq_fire;
    logic             deq_fire;

    // Pointers carry an extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bits means full.
    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) &&
                   (rd_ptr[IDX_W] != wr_ptr[IDX_W]);

`ifdef FDQ_BYPASS_EN
    assign bypass = empty && enq_valid && deq_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction is consumed directly, so it neither writes
    // storage nor moves a pointer.
    assign enq_fire  = enq_valid && !full && !flush && !bypass;
    assign deq_fire  = !empty && !flush && deq_ready;

    assign enq_ready = !full;
    assign deq_valid = (!empty && !flush) || bypass;

    assign head     = mem[rd_ptr[IDX_W-1:0]];
    assign wr_entry = '{instr: instr_in, pc: pc_in, pred: pred_in};

    always_comb begin
        instr_out = head.instr;
        pc_out    = head.pc;
        pred_out  = head.pred;
`ifdef FDQ_BYPASS_EN
        if (bypass) begin
            instr_out = instr_in;
            pc_out    = pc_in;
            pred_out  = pred_in;
        end
`endif
    end

    // Pointer and occupancy state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enq_fire) begin
            mem[wr_ptr[IDX_W-1:0]] <= wr_entry;
        end
    end

    // Occupancy must always equal the pointer distance and stay in range.
    a_count_matches_ptrs : assert property (
        @(posedge CLK) disable iff (!nRST)
        (count == CNT_W'(wr_ptr - rd_ptr)) && (count <= CNT_W'(DEPTH))
    );

endmodule
